// File: rtl/cv32e40x_fifo_gen.sv
// Generic width-parametrised synchronous FIFO with watermarks, push-through
// when full on a same-cycle pop, sticky overflow/underflow flags and
// flush / flush-but-first for pipeline kills.
//
// Ports:
//   clk_i               clock
//   rst_i               synchronous active-high reset
//   flush_i             drop all entries
//   flush_but_first_i   drop all entries except the head
//   clr_err_i           clear sticky error flags
//   data_i / push_i     push data and request
//   data_o / pop_i      head data and pop request
//   full_o, empty_o     occupancy status
//   almost_full_o       cnt_o >= AF_TH
//   almost_empty_o      cnt_o <= AE_TH
//   cnt_o               occupancy
//   overflow_o          sticky: a push was rejected
//   underflow_o         sticky: a pop was rejected
module cv32e40x_fifo_gen #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 8,
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned AF_TH        = DEPTH - 1,
    parameter int unsigned AE_TH        = 1,
    parameter int unsigned ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              flush_but_first_i,
    input  logic              clr_err_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              push_i,
    output logic [WIDTH-1:0]  data_o,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [ADDR_W:0]   cnt_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [ADDR_W-1:0] PtrMax = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CntMax = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   AfTh   = (ADDR_W + 1)'(AF_TH);
    localparam logic [ADDR_W:0]   AeTh   = (ADDR_W + 1)'(AE_TH);

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic cnt_zero;
    logic ft_active;
    logic ft_bypass;
    logic pop_acc;
    logic push_acc;
    logic push_eff;
    logic pop_eff;
    logic do_flush;
    logic do_fbf;
    logic mem_we;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] p);
        return (p == PtrMax) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        cnt_zero  = (cnt_q == '0);
        ft_active = FALL_THROUGH && cnt_zero && push_i;
        // Push and pop in the same fall-through cycle pass data straight
        // across; storage is left untouched.
        ft_bypass = ft_active && pop_i;

        empty_o  = cnt_zero && !ft_active;
        full_o   = (cnt_q == CntMax);
        pop_acc  = pop_i && !empty_o;
        push_acc = push_i && (!full_o || pop_acc);

        push_eff = push_acc && !ft_bypass;
        pop_eff  = pop_acc && !ft_bypass;

        do_flush = flush_i || (flush_but_first_i && cnt_zero);
        do_fbf   = flush_but_first_i && !cnt_zero && !flush_i;
        mem_we   = push_eff && !flush_i && !flush_but_first_i;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;

        if (do_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else if (do_fbf) begin
            wr_ptr_d = wrap_inc(rd_ptr_q);
            cnt_d    = (ADDR_W + 1)'(1);
        end else begin
            if (push_eff) begin
                wr_ptr_d = wrap_inc(wr_ptr_q);
            end
            if (pop_eff) begin
                rd_ptr_d = wrap_inc(rd_ptr_q);
            end
            unique case ({push_eff, pop_eff})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // A new error wins over a same-cycle clear.
    always_comb begin
        ovf_d = (ovf_q && !clr_err_i) || (push_i && !push_acc);
        udf_d = (udf_q && !clr_err_i) || (pop_i && !pop_acc);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            if (mem_we) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    always_comb begin
        data_o         = ft_active ? data_i : mem_q[rd_ptr_q];
        cnt_o          = cnt_q;
        almost_full_o  = (cnt_q >= AfTh);
        almost_empty_o = (cnt_q <= AeTh);
        overflow_o     = ovf_q;
        underflow_o    = udf_q;
    end

endmodule

// File: tb/tb_cv32e40x_fifo_gen.sv
module tb_cv32e40x_fifo_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // DUT A: DEPTH=5, no fall-through, AF_TH=4, AE_TH=1.
    logic       a_flush = 0, a_fbf = 0, a_clr = 0, a_push = 0, a_pop = 0;
    logic [7:0] a_data = '0, a_data_o;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [3:0] a_cnt;

    // DUT B: DEPTH=5, fall-through.
    logic       b_flush = 0, b_fbf = 0, b_clr = 0, b_push = 0, b_pop = 0;
    logic [7:0] b_data = '0, b_data_o;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [3:0] b_cnt;

    cv32e40x_fifo_gen #(
        .WIDTH(8), .DEPTH(5), .FALL_THROUGH(1'b0), .AF_TH(4), .AE_TH(1)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .flush_but_first_i(a_fbf),
        .clr_err_i(a_clr), .data_i(a_data), .push_i(a_push), .data_o(a_data_o),
        .pop_i(a_pop), .full_o(a_full), .empty_o(a_empty), .almost_full_o(a_af),
        .almost_empty_o(a_ae), .cnt_o(a_cnt), .overflow_o(a_ovf), .underflow_o(a_udf)
    );

    cv32e40x_fifo_gen #(
        .WIDTH(8), .DEPTH(5), .FALL_THROUGH(1'b1)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .flush_but_first_i(b_fbf),
        .clr_err_i(b_clr), .data_i(b_data), .push_i(b_push), .data_o(b_data_o),
        .pop_i(b_pop), .full_o(b_full), .empty_o(b_empty), .almost_full_o(b_af),
        .almost_empty_o(b_ae), .cnt_o(b_cnt), .overflow_o(b_ovf), .underflow_o(b_udf)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard for DUT A.
    logic [7:0] sb_q[$];
    bit         m_ovf = 0;
    bit         m_udf = 0;

    task automatic drive_a(input bit psh, input logic [7:0] d, input bit pp,
                           input bit fl, input bit fbf, input bit clr);
        int         sz;
        bit         pop_ok, push_ok;
        logic [7:0] head;
        @(negedge clk);
        a_push = psh; a_data = d; a_pop = pp; a_flush = fl; a_fbf = fbf; a_clr = clr;
        #1;
        sz = sb_q.size();
        check_eq("a_cnt", 32'(a_cnt), 32'(sz));
        check_eq("a_full", 32'(a_full), 32'(sz == 5));
        check_eq("a_empty", 32'(a_empty), 32'(sz == 0));
        check_eq("a_almost_full", 32'(a_af), 32'(sz >= 4));
        check_eq("a_almost_empty", 32'(a_ae), 32'(sz <= 1));
        check_eq("a_overflow", 32'(a_ovf), 32'(m_ovf));
        check_eq("a_underflow", 32'(a_udf), 32'(m_udf));
        if (sz > 0) check_eq("a_head", 32'(a_data_o), 32'(sb_q[0]));
        pop_ok  = pp && (sz > 0);
        push_ok = psh && ((sz < 5) || pop_ok);
        m_ovf   = (m_ovf && !clr) || (psh && !push_ok);
        m_udf   = (m_udf && !clr) || (pp && !pop_ok);
        if (fl || (fbf && sz == 0)) begin
            sb_q.delete();
        end else if (fbf) begin
            head = sb_q[0];
            sb_q.delete();
            sb_q.push_back(head);
        end else begin
            if (pop_ok) void'(sb_q.pop_front());
            if (push_ok) sb_q.push_back(d);
        end
        @(posedge clk);
    endtask

    task automatic idle_a();
        drive_a(0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        a_push = 0; a_pop = 0; a_flush = 0; a_fbf = 0; a_clr = 0; a_data = 8'h5A;
        b_push = 0; b_pop = 0; b_flush = 0; b_fbf = 0; b_clr = 0; b_data = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check_eq("rst_a_cnt", 32'(a_cnt), 0);
        check_eq("rst_a_full", 32'(a_full), 0);
        check_eq("rst_a_empty", 32'(a_empty), 1);
        check_eq("rst_a_af", 32'(a_af), 0);
        check_eq("rst_a_ae", 32'(a_ae), 1);
        check_eq("rst_a_ovf", 32'(a_ovf), 0);
        check_eq("rst_a_udf", 32'(a_udf), 0);
        check_eq("rst_a_data", 32'(a_data_o), 0);
        check_eq("rst_b_cnt", 32'(b_cnt), 0);
        check_eq("rst_b_empty", 32'(b_empty), 1);
        check_eq("rst_b_data", 32'(b_data_o), 0);
        sb_q.delete();
        m_ovf = 0;
        m_udf = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Fill, overflow, drain in order, underflow, clear.
        for (int i = 0; i < 5; i++) drive_a(1, 8'hA1 + 8'(i), 0, 0, 0, 0);
        drive_a(1, 8'hA6, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive_a(0, 8'h00, 1, 0, 0, 0);
        drive_a(0, 8'h00, 1, 0, 0, 0);
        drive_a(0, 8'h00, 0, 0, 0, 1);
        idle_a();

        // Sustained push+pop at occupancy 3 wraps both pointers.
        for (int i = 0; i < 3; i++) drive_a(1, 8'h10 + 8'(i), 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) drive_a(1, 8'h20 + 8'(i), 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive_a(0, 8'h00, 1, 0, 0, 0);
        idle_a();

        // Push-through while full.
        for (int i = 0; i < 5; i++) drive_a(1, 8'hE0 + 8'(i), 0, 0, 0, 0);
        drive_a(1, 8'hB0, 1, 0, 0, 0);
        idle_a();
        for (int i = 0; i < 5; i++) drive_a(0, 8'h00, 1, 0, 0, 0);
        idle_a();

        // Flush-but-first keeps the head and drops the same-cycle push.
        for (int i = 0; i < 4; i++) drive_a(1, 8'hD0 + 8'(i), 0, 0, 0, 0);
        drive_a(1, 8'hFF, 0, 0, 1, 0);
        idle_a();
        drive_a(1, 8'hEE, 0, 1, 0, 0);
        idle_a();
        drive_a(0, 8'h00, 0, 0, 1, 0);
        idle_a();

        // Watermarks across 0..5, then reset at occupancy 3.
        for (int i = 0; i < 5; i++) drive_a(1, 8'h40 + 8'(i), 0, 0, 0, 0);
        idle_a();
        drive_a(0, 8'h00, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive_a(1, 8'h60 + 8'(i), 0, 0, 0, 0);
        idle_a();
        do_reset();

        // Fall-through: same-cycle push and pop on empty.
        @(negedge clk);
        b_push = 1; b_data = 8'hC3; b_pop = 1;
        #1;
        check_eq("b_ft_data", 32'(b_data_o), 32'h0C3);
        check_eq("b_ft_empty", 32'(b_empty), 0);
        check_eq("b_ft_cnt", 32'(b_cnt), 0);
        @(posedge clk);
        @(negedge clk);
        b_push = 0; b_pop = 0;
        #1;
        check_eq("b_after_cnt", 32'(b_cnt), 0);
        check_eq("b_after_empty", 32'(b_empty), 1);
        check_eq("b_after_udf", 32'(b_udf), 0);
        check_eq("b_after_ovf", 32'(b_ovf), 0);
        b_pop = 1;
        @(posedge clk);
        @(negedge clk);
        b_pop = 0;
        #1;
        check_eq("b_udf_set", 32'(b_udf), 1);
        b_clr = 1;
        @(posedge clk);
        @(negedge clk);
        b_clr = 0;
        #1;
        check_eq("b_udf_clr", 32'(b_udf), 0);
        b_push = 1; b_data = 8'hC4;
        #1;
        check_eq("b_ft_push_data", 32'(b_data_o), 32'h0C4);
        check_eq("b_ft_push_empty", 32'(b_empty), 0);
        @(posedge clk);
        @(negedge clk);
        b_push = 0;
        #1;
        check_eq("b_stored_cnt", 32'(b_cnt), 1);
        check_eq("b_stored_data", 32'(b_data_o), 32'h0C4);
        check_eq("b_stored_empty", 32'(b_empty), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
